// File: rtl/uart_rx_framed.sv
// uart_rx_framed: parametrised UART receiver (5..9 data bits, optional parity, 1/2 stop bits)
// with 3-sample majority voting, false-start rejection and a valid/ready holding register.
`default_nettype none

module pulse_gen #(
  parameter int ACC_WIDTH = 1,
  parameter int ACC_INCR  = 2
) (
  input  logic clk,
  input  logic rst,
  output logic pulse
);
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH:0]   sum;

  // The carry out of the phase accumulator is the tick.
  assign sum   = {1'b0, acc} + (ACC_WIDTH+1)'(ACC_INCR);
  assign pulse = sum[ACC_WIDTH];

  always_ff @(posedge clk) begin
    if (rst) acc <= '0;
    else     acc <= sum[ACC_WIDTH-1:0];
  end
endmodule

module uart_rx_framed #(
  parameter int baud_acc_width = 1,
  parameter int baud_acc_incr  = 2,
  parameter int DATA_BITS      = 8,
  parameter int PARITY         = 0,
  parameter int STOP_BITS      = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_overrun
);
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic       LAST_STOP = (STOP_BITS == 2);

  state_t               state, state_n;
  logic                 rx_meta, rx_sync, baud_x16;
  logic [3:0]           tick_cnt, tick_cnt_n, bit_idx, bit_idx_n;
  logic [1:0]           samp, samp_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 par_acc, par_acc_n, par_err, par_err_n;
  logic                 fr_err, fr_err_n, stop_idx, stop_idx_n;
  logic                 bit_val, mid, wrap, done;

  pulse_gen #(
    .ACC_WIDTH (baud_acc_width),
    .ACC_INCR  (baud_acc_incr)
  ) u_tick (
    .clk   (i_clk),
    .rst   (i_rst),
    .pulse (baud_x16)
  );

  // Third vote is the live sample at tick 9.
  assign bit_val = (samp[0] & samp[1]) | (samp[0] & rx_sync) | (samp[1] & rx_sync);
  assign mid     = (tick_cnt == 4'd9);
  assign wrap    = (tick_cnt == 4'd15);

  always_comb begin
    state_n    = state;
    tick_cnt_n = tick_cnt;
    bit_idx_n  = bit_idx;
    samp_n     = samp;
    shreg_n    = shreg;
    par_acc_n  = par_acc;
    par_err_n  = par_err;
    fr_err_n   = fr_err;
    stop_idx_n = stop_idx;
    done       = 1'b0;
    if (baud_x16) begin
      tick_cnt_n = tick_cnt + 4'd1;
      if (tick_cnt == 4'd7) samp_n[0] = rx_sync;
      if (tick_cnt == 4'd8) samp_n[1] = rx_sync;
      case (state)
        IDLE: begin
          tick_cnt_n = 4'd0;
          if (!rx_sync) begin
            state_n    = START;
            par_acc_n  = 1'b0;
            par_err_n  = 1'b0;
            fr_err_n   = 1'b0;
            stop_idx_n = 1'b0;
          end
        end
        START: begin
          if (mid && bit_val) begin
            state_n    = IDLE;
            tick_cnt_n = 4'd0;
          end else if (wrap) begin
            state_n   = DATA;
            bit_idx_n = 4'd0;
          end
        end
        DATA: begin
          if (mid) begin
            shreg_n   = {bit_val, shreg[DATA_BITS-1:1]};
            par_acc_n = par_acc ^ bit_val;
          end
          if (wrap) begin
            if (bit_idx == LAST_BIT) state_n = (PARITY != 0) ? PAR : STOP;
            else                     bit_idx_n = bit_idx + 4'd1;
          end
        end
        PAR: begin
          if (mid) par_err_n = (PARITY == 1) ? ~(par_acc ^ bit_val) : (par_acc ^ bit_val);
          if (wrap) state_n = STOP;
        end
        STOP: begin
          if (mid) begin
            fr_err_n = fr_err | ~bit_val;
            if (stop_idx == LAST_STOP) begin
              done       = 1'b1;
              state_n    = IDLE;
              tick_cnt_n = 4'd0;
            end
          end else if (wrap) begin
            stop_idx_n = 1'b1;
          end
        end
        default: begin
          state_n    = IDLE;
          tick_cnt_n = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      state    <= IDLE;
      tick_cnt <= 4'd0;
      bit_idx  <= 4'd0;
      samp     <= 2'b11;
      shreg    <= '0;
      par_acc  <= 1'b0;
      par_err  <= 1'b0;
      fr_err   <= 1'b0;
      stop_idx <= 1'b0;
    end else begin
      rx_meta  <= i_rx;
      rx_sync  <= rx_meta;
      state    <= state_n;
      tick_cnt <= tick_cnt_n;
      bit_idx  <= bit_idx_n;
      samp     <= samp_n;
      shreg    <= shreg_n;
      par_acc  <= par_acc_n;
      par_err  <= par_err_n;
      fr_err   <= fr_err_n;
      stop_idx <= stop_idx_n;
    end
  end

  // A completing frame wins over a same-cycle consume; a blocked one is dropped.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      o_overrun <= 1'b0;
      if (done) begin
        if (!o_valid || i_ready) begin
          o_data       <= shreg;
          o_parity_err <= par_err;
          o_frame_err  <= fr_err_n;
          o_valid      <= 1'b1;
        end else begin
          o_overrun <= 1'b1;
        end
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_uart_rx_framed.sv
// Directed bench for uart_rx_framed: three instances (8N1, 7E1, 8N2) on a shared clock,
// baud tick every clock so one bit lasts 16 clocks.
`default_nettype none

module tb_uart_rx_framed;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;
  logic ready_a = 1'b1, ready_b = 1'b1, ready_c = 1'b1;
  logic [7:0] data_a, data_c;
  logic [6:0] data_b;
  logic valid_a, valid_b, valid_c, pe_a, pe_b, pe_c, fe_a, fe_b, fe_c, ovr_a, ovr_b, ovr_c;

  int checks = 0;
  int errors = 0;
  int acc_a = 0, acc_b = 0, acc_c = 0, vcyc_a = 0, ovr_cnt_a = 0;
  logic [7:0] cap_a, cap_c;
  logic [6:0] cap_b;
  logic cpe_a, cfe_a, cpe_b, cfe_b, cpe_c, cfe_c;

  always #5 clk = ~clk;

  uart_rx_framed #(.baud_acc_width(1), .baud_acc_incr(2), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
    .i_clk(clk), .i_rst(rst), .i_rx(rx_a), .o_data(data_a), .o_valid(valid_a), .i_ready(ready_a),
    .o_parity_err(pe_a), .o_frame_err(fe_a), .o_overrun(ovr_a));
  uart_rx_framed #(.baud_acc_width(1), .baud_acc_incr(2), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u_b (
    .i_clk(clk), .i_rst(rst), .i_rx(rx_b), .o_data(data_b), .o_valid(valid_b), .i_ready(ready_b),
    .o_parity_err(pe_b), .o_frame_err(fe_b), .o_overrun(ovr_b));
  uart_rx_framed #(.baud_acc_width(1), .baud_acc_incr(2), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_c (
    .i_clk(clk), .i_rst(rst), .i_rx(rx_c), .o_data(data_c), .o_valid(valid_c), .i_ready(ready_c),
    .o_parity_err(pe_c), .o_frame_err(fe_c), .o_overrun(ovr_c));

  // Capture every accepted frame so the main sequence can check it afterwards.
  always @(negedge clk) begin
    if (valid_a && ready_a) begin acc_a <= acc_a + 1; cap_a <= data_a; cpe_a <= pe_a; cfe_a <= fe_a; end
    if (valid_a) vcyc_a <= vcyc_a + 1;
    if (ovr_a) ovr_cnt_a <= ovr_cnt_a + 1;
    if (valid_b && ready_b) begin acc_b <= acc_b + 1; cap_b <= data_b; cpe_b <= pe_b; cfe_b <= fe_b; end
    if (valid_c && ready_c) begin acc_c <= acc_c + 1; cap_c <= data_c; cpe_c <= pe_c; cfe_c <= fe_c; end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int line, input logic v);
    case (line)
      0:       rx_a = v;
      1:       rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // bits[0] is the start bit; glitch_at inverts one clock, rst_at pulses reset for one clock.
  task automatic send(input int line, input logic [15:0] bits, input int nbits,
                      input int glitch_at, input int rst_at);
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < 16; c++) begin
        @(negedge clk);
        drive(line, bits[b] ^ ((b * 16 + c) == glitch_at));
        rst = ((b * 16 + c) == rst_at);
      end
    end
    @(negedge clk);
    drive(line, 1'b1);
    rst = 1'b0;
  endtask

  initial begin
    repeat (5) @(negedge clk);
    rst = 1'b0;
    idle(3);
    chk("reset_data", data_a, 0);
    chk("reset_valid", valid_a, 0);
    chk("reset_perr", pe_a, 0);
    chk("reset_ferr", fe_a, 0);
    chk("reset_overrun", ovr_a, 0);

    // 8N1 0xA5 with ready held high
    send(0, {1'b1, 8'hA5, 1'b0}, 10, -1, -1);
    idle(40);
    chk("a5_count", acc_a, 1);
    chk("a5_data", cap_a, 8'hA5);
    chk("a5_perr", cpe_a, 0);
    chk("a5_ferr", cfe_a, 0);
    chk("a5_valid_cycles", vcyc_a, 1);

    // 7E1: 0x41 has two ones, so parity bit 0 is correct and 1 is wrong
    send(1, {1'b1, 1'b0, 7'h41, 1'b0}, 10, -1, -1);
    idle(40);
    chk("even_ok_count", acc_b, 1);
    chk("even_ok_data", cap_b, 7'h41);
    chk("even_ok_perr", cpe_b, 0);
    send(1, {1'b1, 1'b1, 7'h41, 1'b0}, 10, -1, -1);
    idle(40);
    chk("even_bad_count", acc_b, 2);
    chk("even_bad_data", cap_b, 7'h41);
    chk("even_bad_perr", cpe_b, 1);
    chk("even_bad_ferr", cfe_b, 0);

    // 4-clock low glitch on an idle line is a false start
    for (int i = 0; i < 4; i++) begin @(negedge clk); rx_a = 1'b0; end
    @(negedge clk); rx_a = 1'b1;
    idle(60);
    chk("glitch_idle_count", acc_a, 1);

    // single-clock glitch on the tick-8 sample of data bit 0 is outvoted
    send(0, {1'b1, 8'hA5, 1'b0}, 10, 25, -1);
    idle(40);
    chk("glitch_bit_count", acc_a, 2);
    chk("glitch_bit_data", cap_a, 8'hA5);
    chk("glitch_bit_ferr", cfe_a, 0);

    // 8N2 0x3C with second stop bit low
    send(2, {1'b0, 1'b1, 8'h3C, 1'b0}, 11, -1, -1);
    idle(60);
    chk("stop2_count", acc_c, 1);
    chk("stop2_data", cap_c, 8'h3C);
    chk("stop2_ferr", cfe_c, 1);
    chk("stop2_perr", cpe_c, 0);

    // break: the whole frame including stop held low
    send(0, 16'h0000, 10, -1, -1);
    idle(60);
    chk("break_count", acc_a, 3);
    chk("break_data", cap_a, 8'h00);
    chk("break_ferr", cfe_a, 1);

    // overrun with the consumer stalled
    @(posedge clk); #1 ready_a = 1'b0;
    send(0, {1'b1, 8'h11, 1'b0}, 10, -1, -1);
    idle(40);
    chk("ovr_first_valid", valid_a, 1);
    chk("ovr_first_data", data_a, 8'h11);
    chk("ovr_first_pulses", ovr_cnt_a, 0);
    send(0, {1'b1, 8'h22, 1'b0}, 10, -1, -1);
    idle(40);
    chk("ovr_held_data", data_a, 8'h11);
    chk("ovr_held_valid", valid_a, 1);
    chk("ovr_pulses", ovr_cnt_a, 1);
    chk("ovr_no_accept", acc_a, 3);
    @(posedge clk); #1 ready_a = 1'b1;
    idle(3);
    chk("ovr_release_valid", valid_a, 0);
    chk("ovr_release_count", acc_a, 4);
    chk("ovr_release_data", cap_a, 8'h11);

    // reset pulse during bit 3 of 0x55; the sender aborts with the receiver
    send(0, {1'b1, 1'b0, 1'b1, 1'b0}, 4, -1, 56);
    idle(200);
    chk("rst_mid_count", acc_a, 4);
    chk("rst_mid_valid", valid_a, 0);
    chk("rst_mid_data", data_a, 0);
    chk("rst_mid_perr", pe_a, 0);
    chk("rst_mid_ferr", fe_a, 0);
    chk("rst_mid_overrun", ovr_a, 0);
    send(0, {1'b1, 8'h55, 1'b0}, 10, -1, -1);
    idle(40);
    chk("after_rst_count", acc_a, 5);
    chk("after_rst_data", cap_a, 8'h55);
    chk("after_rst_ferr", cfe_a, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/uart_rx_framed.md
# uart_rx_framed

Parametrised UART receiver, successor to the fixed 8N1 receiver. It supports configurable data width, optional parity and one or two stop bits. It uses 3-sample majority voting and false-start rejection, and reports parity and framing errors. Output is a valid/ready holding register with overrun reporting. It sits between the board RX pin and byte-consuming logic (command decoder, FIFO), sharing the same `pulse_gen` baud tick scheme.

## Interface
- `baud_acc_width`, default 1: accumulator width of the internal `pulse_gen` producing the 16x baud tick.
- `baud_acc_incr`, default 2: accumulator increment of the internal `pulse_gen`.
- `DATA_BITS`, default 8: data bits per frame, legal 5..9.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: legal 1 or 2.
- `i_clk`  in  1  sole clock.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_rx`  in  1  asynchronous serial line, idle high.
- `o_data`  out  DATA_BITS  received word, LSB = first bit on the wire.
- `o_valid`  out  1  `o_data` and the error flags hold an unconsumed frame.
- `i_ready`  in  1  consumer accepts the frame when `o_valid && i_ready`.
- `o_parity_err`  out  1  parity mismatch for the held frame; always 0 when `PARITY=0`.
- `o_frame_err`  out  1  a stop bit of the held frame sampled 0.
- `o_overrun`  out  1  one-cycle pulse: a completed frame was dropped.

## Operation
- **Synchroniser.** `i_rx` passes through 2 flops into `rx_sync`. Both flops reset to 1.
- **Tick.** `baud_x16` comes from `pulse_gen`. All sampling logic advances only on `baud_x16`.
- **Tick counter.**
  - 4-bit `tick_cnt` within the bit.
  - Samples are taken at tick_cnt 7, 8 and 9.
  - `bit_val` is the majority of the 3 samples and is valid at tick 9.
  - `tick_cnt` wraps 15→0 and advances to the next bit.
- **State machine:** IDLE, START, DATA, PAR, STOP.
  - **IDLE:** on a tick with `rx_sync==0`, go to START with `tick_cnt=0`.
  - **START:** at tick 9, if `bit_val==1`, it was a false start; return to IDLE with no output. Otherwise continue. At wrap, go to DATA with `bit_idx=0`.
  - **DATA:** at tick 9, shift `bit_val` into the shift register, LSB first, and update the running parity. At wrap, increment `bit_idx`. After bit DATA_BITS-1, go to PAR if `PARITY!=0`, else STOP.
  - **PAR:** at tick 9, compare. Odd parity requires XOR(data, parity bit)=1; even requires 0. Record the mismatch. At wrap, go to STOP.
  - **STOP:**
    - With `STOP_BITS=2`, sample the first stop bit at tick 9, then wrap into the second.
    - At tick 9 of the last stop bit, the frame is complete; return to IDLE immediately, without waiting for the wrap.
    - `frame_err` = any stop sample == 0.
- **Frame completion.**
  - If `!o_valid || i_ready`: load `o_data`, `o_parity_err` and `o_frame_err`, and set `o_valid`.
  - Else: pulse `o_overrun` for 1 cycle, drop the new frame, and leave the held frame untouched.
- **Consumption.** `o_valid && i_ready` with no completion in the same cycle clears `o_valid`. The flags keep their values but are meaningful only while `o_valid`.
- **Error frames** are still delivered. A break (line held low) yields `o_frame_err=1` and data all-zero.
- **Width.** `bit_idx` is 4 bits. The shift register is DATA_BITS wide.

## Timing
- **Reset values:** `o_data=0`, `o_valid=0`, `o_parity_err=0`, `o_frame_err=0`, `o_overrun=0`, state IDLE, `tick_cnt=0`, synchroniser=1.
- **Reset mid-frame** aborts the frame and produces no output. Line activity during reset is ignored. After reset, a line still low is treated as a new start.
- **Latency:** `o_valid` rises 1 clock after the `baud_x16` edge on which the last stop bit is voted. That is about 2 clocks (synchroniser) + 1 tick + (1+DATA_BITS+P+STOP_BITS-1)·16+9 ticks after the falling edge, where P=1 if `PARITY!=0`.
- **Same-cycle cases:**
  - Completion in the same cycle as `o_valid && i_ready`: the new frame is loaded, `o_valid` stays 1, no overrun.
  - Completion with `o_valid && !i_ready`: overrun.
- **Back-to-back frames:** a start edge arriving 0.5 bit after the stop-bit vote is detected.
- **Handshake:** `o_valid` never drops without `i_ready`, and `o_data` is stable while `o_valid && !i_ready`.

## Test plan
Bench configures `pulse_gen` so `baud_x16` fires every clock (bit = 16 clocks).
- **8N1, byte 0xA5, `i_ready=1`:** `o_valid` for 1 cycle with `o_data=0xA5`, both error flags 0.
- **DATA_BITS=7, PARITY=2 (even):** send 0x41 with parity 0, then 0x41 with parity 1. Frame 1 has `o_parity_err=0`; frame 2 has `o_parity_err=1`. `o_data=0x41` both times.
- **Noise handling:**
  - 4-clock low glitch on idle line: no `o_valid`, state back in IDLE.
  - 1-clock glitch at tick 8 of a data bit: the majority vote keeps the correct bit.
- **STOP_BITS=2, 0x3C with second stop bit 0:** `o_data=0x3C`, `o_frame_err=1`.
- **Overrun:** `i_ready=0`, send 0x11 then 0x22. `o_data` stays 0x11 and `o_overrun` pulses once at the completion of 0x22. Raising `i_ready` clears `o_valid`.
- **Reset:** assert `i_rst` for 1 clock during bit 3 of 0x55. No `o_valid`, and all outputs match their reset values. A following 0x55 is received correctly.
